// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
package pipeline_pkg;

    typedef enum logic [1:0] {
        StRun,
        StLoadBubble,
        StMemWait,
        StFault
    } pipe_state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline stall/flush controller: load-use bubbles, branch flushes,
// data-memory wait stalls with a timeout fault, and a saturating stall-cycle counter.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ld_hazard_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    input  logic             cnt_clr_i,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             id_ex_en_o,
    output logic             ex_mem_en_o,
    output logic             mem_wb_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             timeout_o
);

    localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);

    pipe_state_e      state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;

    logic use_rules, mem_stall, ld_ok;

    always_comb begin
        pc_en_o       = 1'b1;
        if_id_en_o    = 1'b1;
        id_ex_en_o    = 1'b1;
        ex_mem_en_o   = 1'b1;
        mem_wb_en_o   = 1'b1;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        timeout_o     = 1'b0;
        state_d       = state_q;
        wait_d        = '0;
        use_rules     = 1'b0;
        mem_stall     = 1'b0;
        ld_ok         = 1'b0;

        unique case (state_q)
            StRun: begin
                use_rules = 1'b1;
                mem_stall = dmem_req_i && !dmem_ack_i;
                ld_ok     = 1'b1;
            end
            StLoadBubble: begin
                use_rules = 1'b1;
                mem_stall = dmem_req_i && !dmem_ack_i;
            end
            StMemWait: begin
                if (dmem_ack_i) begin
                    // Access completes: resolve branch/load for this same cycle.
                    use_rules = 1'b1;
                    ld_ok     = 1'b1;
                end else begin
                    mem_stall = 1'b1;
                    wait_d    = wait_q + WaitW'(1);
                    if (wait_q == WaitLast) begin
                        state_d = StFault;
                    end
                end
            end
            StFault: begin
                timeout_o = 1'b1;
                wait_d    = wait_q;
            end
            default: state_d = StRun;
        endcase

        if (mem_stall || (state_q == StFault)) begin
            pc_en_o     = 1'b0;
            if_id_en_o  = 1'b0;
            id_ex_en_o  = 1'b0;
            ex_mem_en_o = 1'b0;
            mem_wb_en_o = 1'b0;
            if (use_rules) begin
                state_d = StMemWait;
            end
        end else if (use_rules) begin
            state_d = StRun;
            if (branch_taken_i) begin
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end else if (ld_hazard_i && ld_ok) begin
                pc_en_o       = 1'b0;
                if_id_en_o    = 1'b0;
                id_ex_flush_o = 1'b1;
                state_d       = StLoadBubble;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StRun;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (!pc_en_o),
        .clr_i (cnt_clr_i),
        .cnt_o (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver queues expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_pipeline_ctrl;

    localparam int unsigned CntW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ld_hazard = 1'b0;
    logic            branch_taken = 1'b0;
    logic            dmem_req = 1'b0;
    logic            dmem_ack = 1'b0;
    logic            cnt_clr = 1'b0;
    logic            pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic            if_id_flush, id_ex_flush, timeout;
    logic [CntW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id_flush, id_ex_flush, timeout, stall_cnt}
    logic [11:0] exp_q[$];
    string       name_q[$];
    int          sc_model = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (CntW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ld_hazard_i    (ld_hazard),
        .branch_taken_i (branch_taken),
        .dmem_req_i     (dmem_req),
        .dmem_ack_i     (dmem_ack),
        .cnt_clr_i      (cnt_clr),
        .pc_en_o        (pc_en),
        .if_id_en_o     (if_id_en),
        .id_ex_en_o     (id_ex_en),
        .ex_mem_en_o    (ex_mem_en),
        .mem_wb_en_o    (mem_wb_en),
        .if_id_flush_o  (if_id_flush),
        .id_ex_flush_o  (id_ex_flush),
        .stall_cnt_o    (stall_cnt),
        .timeout_o      (timeout)
    );

    // One cycle of stimulus; expected stall count comes from a saturating model.
    task automatic step(input string nm, input logic r, input logic ld, input logic br,
                        input logic rq, input logic ak, input logic clr,
                        input logic [4:0] en, input logic [1:0] fl, input logic to);
        @(posedge clk);
        #1;
        rst = r; ld_hazard = ld; branch_taken = br;
        dmem_req = rq; dmem_ack = ak; cnt_clr = clr;
        if (r) sc_model = 0;
        exp_q.push_back({en, fl, to, CntW'(sc_model)});
        name_q.push_back(nm);
        if (!r) begin
            if (clr) sc_model = 0;
            else if (!en[4] && sc_model < 15) sc_model++;
        end
    endtask

    initial begin : monitor
        logic [11:0] act, exp;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_flush, id_ex_flush, timeout, stall_cnt};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL %s: got en=%b fl=%b to=%b cnt=%0d, want en=%b fl=%b to=%b cnt=%0d",
                             nm, act[11:7], act[6:5], act[4], act[3:0],
                             exp[11:7], exp[6:5], exp[4], exp[3:0]);
                end
            end
        end
    end

    initial begin : driver
        int budget;
        step("reset",        1, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 0);
        step("idle",         0, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 0);
        step("ld_hazard",    0, 1, 0, 0, 0, 0, 5'b00111, 2'b01, 0);
        step("ld_bubble",    0, 1, 0, 0, 0, 0, 5'b11111, 2'b00, 0);
        step("after_bubble", 0, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 0);
        step("branch_ld",    0, 1, 1, 0, 0, 0, 5'b11111, 2'b11, 0);
        step("no_bubble",    0, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 0);
        step("clr",          0, 0, 0, 0, 0, 1, 5'b11111, 2'b00, 0);
        step("mem_req",      0, 0, 0, 1, 0, 0, 5'b00000, 2'b00, 0);
        for (int i = 0; i < 4; i++)
            step("mem_wait", 0, 0, 0, 1, 0, 0, 5'b00000, 2'b00, 0);
        step("mem_ack",      0, 0, 0, 1, 1, 0, 5'b11111, 2'b00, 0);
        step("stall_five",   0, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 0);
        step("mem_req2",     0, 0, 0, 1, 0, 0, 5'b00000, 2'b00, 0);
        step("ack_ld",       0, 1, 0, 1, 1, 0, 5'b00111, 2'b01, 0);
        step("bubble_mem",   0, 1, 0, 1, 0, 0, 5'b00000, 2'b00, 0);
        step("ack_branch",   0, 0, 1, 1, 1, 0, 5'b11111, 2'b11, 0);
        step("idle2",        0, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 0);
        step("ld_hazard2",   0, 1, 0, 0, 0, 0, 5'b00111, 2'b01, 0);
        step("bubble_br",    0, 1, 1, 0, 0, 0, 5'b11111, 2'b11, 0);
        step("idle3",        0, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 0);
        step("clr2",         0, 0, 0, 0, 0, 1, 5'b11111, 2'b00, 0);
        step("to_req",       0, 0, 0, 1, 0, 0, 5'b00000, 2'b00, 0);
        for (int i = 0; i < 8; i++)
            step("to_wait",  0, 0, 0, 1, 0, 0, 5'b00000, 2'b00, 0);
        step("fault",        0, 0, 0, 1, 0, 0, 5'b00000, 2'b00, 1);
        step("fault_ack",    0, 1, 1, 1, 1, 0, 5'b00000, 2'b00, 1);
        step("fault_clr",    0, 0, 0, 0, 0, 1, 5'b00000, 2'b00, 1);
        for (int i = 0; i < 20; i++)
            step("sat",      0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 1);
        step("clr_stall",    0, 0, 0, 0, 0, 1, 5'b00000, 2'b00, 1);
        step("cleared",      0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 1);
        step("rst_fault",    1, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 0);
        step("post_rst",     0, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 0);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
